// File: rtl/mips_cpu_div_if.sv
// Divider request/result bundle.
// master drives start/signdiv/a/b; slave returns q/r/busy/divdone.
interface mips_cpu_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signdiv;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             divdone;

  modport master (
    output start, signdiv, a, b,
    input  q, r, busy, divdone
  );

  modport slave (
    input  start, signdiv, a, b,
    output q, r, busy, divdone
  );
endinterface

// File: rtl/mips_cpu_div.sv
// MIPS DIV/DIVU unit: restoring shift-subtract, one bit per cycle.
// Ports: clk, divrst (sync, active-high), bus (slave: start/signdiv/a/b in, q/r/busy/divdone out).
module mips_cpu_div #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           divrst,
  mips_cpu_div_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sdiv_q, sdiv_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   trial;

  always_comb begin
    a_neg  = bus.signdiv & bus.a[WIDTH-1];
    b_neg  = bus.signdiv & bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
    accept = bus.start &
             ((state_q == IDLE) | (state_q == DONE));
    // dvd_q shifts dividend bits out the top and
    // quotient bits in at the bottom.
    trial  = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    sdiv_d  = sdiv_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          sdiv_d = bus.signdiv;
          sa_d   = bus.a[WIDTH-1];
          sb_d   = bus.b[WIDTH-1];
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          rem_d  = '0;
          cnt_d  = '0;
          if (bus.b == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = bus.a;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      CALC: begin
        // Borrow out means the trial went negative: restore.
        if (trial[WIDTH]) begin
          rem_d = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        end else begin
          rem_d = trial[WIDTH-1:0];
        end
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        q_d = (sdiv_q & (sa_q ^ sb_q)) ? -dvd_q : dvd_q;
        r_d = (sdiv_q & sa_q) ? -rem_q : rem_q;
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (divrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sdiv_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdiv_q  <= sdiv_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.r       = r_q;
  assign bus.busy    = busy_q;
  assign bus.divdone = done_q;

endmodule

// File: tb/tb_mips_cpu_div.sv
// Directed bench for mips_cpu_div.
// Latency counts posedges with the accepting edge as edge 1.
module tb_mips_cpu_div;

  logic clk;
  logic divrst;
  int   checks;
  int   errors;

  mips_cpu_div_if #(.WIDTH(32)) bus ();

  mips_cpu_div #(.WIDTH(32)) dut (
    .clk    (clk),
    .divrst (divrst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then scramble the operands.
  task automatic do_start(input logic sd,
                          input logic [31:0] av,
                          input logic [31:0] bv);
    bus.start   = 1'b1;
    bus.signdiv = sd;
    bus.a       = av;
    bus.b       = bv;
    step();
    bus.start   = 1'b0;
    bus.signdiv = ~sd;
    bus.a       = 32'hDEAD_BEEF;
    bus.b       = 32'h0000_0003;
  endtask

  // Waits for divdone. inj > 0 injects a start pulse at that edge count.
  task automatic wait_done(input  int inj,
                           input  logic [31:0] hold_q,
                           output int lat,
                           output int bcnt,
                           output int qmoved);
    lat    = 1;
    bcnt   = 0;
    qmoved = 0;
    while (!bus.divdone && lat < 100) begin
      if (bus.busy) bcnt++;
      if (bus.q !== hold_q) qmoved = 1;
      if (lat == inj) begin
        bus.start   = 1'b1;
        bus.signdiv = 1'b0;
        bus.a       = 32'd9;
        bus.b       = 32'd4;
      end else begin
        bus.start = 1'b0;
      end
      step();
      lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    divrst      = 1'b1;
    bus.start   = 1'b1;
    bus.signdiv = 1'b0;
    bus.a       = 32'd100;
    bus.b       = 32'd7;
    step();
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.q !== 32'd0) begin
      errors++;
      $display("FAIL rst_q got %h exp 0", bus.q);
    end
    checks++;
    if (bus.r !== 32'd0) begin
      errors++;
      $display("FAIL rst_r got %h exp 0", bus.r);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b exp 0", bus.busy);
    end
    checks++;
    if (bus.divdone !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got %b exp 0", bus.divdone);
    end
    divrst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    int lat, bc, qm;
    do_start(1'b0, 32'd100, 32'd7);
    wait_done(0, 32'd0, lat, bc, qm);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL uns_lat got %0d exp 34", lat);
    end
    checks++;
    if (bc !== 33) begin
      errors++;
      $display("FAIL uns_busy_cycles got %0d exp 33", bc);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL uns_busy_end got %b exp 0", bus.busy);
    end
    checks++;
    if (bus.q !== 32'd14 || bus.r !== 32'd2) begin
      errors++;
      $display("FAIL uns_qr got %0d/%0d exp 14/2", bus.q, bus.r);
    end
    bus.a = 32'h1234_5678;
    bus.b = 32'h0;
    repeat (5) step();
    checks++;
    if (bus.divdone !== 1'b1 || bus.q !== 32'd14 ||
        bus.r !== 32'd2) begin
      errors++;
      $display("FAIL uns_hold got d=%b q=%0d r=%0d exp 1/14/2",
               bus.divdone, bus.q, bus.r);
    end
  endtask

  task automatic test_signed();
    int lat, bc, qm;
    do_start(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 32'd14, lat, bc, qm);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL sgn_lat got %0d exp 34", lat);
    end
    checks++;
    if (bus.q !== 32'hFFFF_FFFD || bus.r !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sgn_qr got %h/%h exp fffffffd/ffffffff",
               bus.q, bus.r);
    end
    do_start(1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 32'hFFFF_FFFD, lat, bc, qm);
    checks++;
    if (bus.q !== 32'h7FFF_FFFC || bus.r !== 32'd1) begin
      errors++;
      $display("FAIL sgn_u_qr got %h/%h exp 7ffffffc/00000001",
               bus.q, bus.r);
    end
  endtask

  task automatic test_divzero();
    bus.start   = 1'b1;
    bus.signdiv = 1'b0;
    bus.a       = 32'd5;
    bus.b       = 32'd0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_busy_pre got %b exp 0", bus.busy);
    end
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.divdone !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_flags got d=%b b=%b exp 1/0",
               bus.divdone, bus.busy);
    end
    checks++;
    if (bus.q !== 32'hFFFF_FFFF || bus.r !== 32'd5) begin
      errors++;
      $display("FAIL dz_qr got %h/%h exp ffffffff/00000005",
               bus.q, bus.r);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.divdone !== 1'b1) begin
      errors++;
      $display("FAIL dz_after got b=%b d=%b exp 0/1",
               bus.busy, bus.divdone);
    end
    do_start(1'b1, 32'hFFFF_FFFD, 32'd0);
    checks++;
    if (bus.q !== 32'hFFFF_FFFF || bus.r !== 32'hFFFF_FFFD ||
        bus.divdone !== 1'b1) begin
      errors++;
      $display("FAIL dz_sgn got %h/%h d=%b exp ffffffff/fffffffd/1",
               bus.q, bus.r, bus.divdone);
    end
  endtask

  task automatic test_overflow();
    int lat, bc, qm;
    do_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, 32'hFFFF_FFFF, lat, bc, qm);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL ovf_lat got %0d exp 34", lat);
    end
    checks++;
    if (bus.q !== 32'h8000_0000 || bus.r !== 32'd0) begin
      errors++;
      $display("FAIL ovf_qr got %h/%h exp 80000000/00000000",
               bus.q, bus.r);
    end
  endtask

  task automatic test_abort();
    do_start(1'b0, 32'd100, 32'd7);
    repeat (9) step();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_mid_busy got %b exp 1", bus.busy);
    end
    divrst = 1'b1;
    step();
    divrst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.divdone !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags got b=%b d=%b exp 0/0",
               bus.busy, bus.divdone);
    end
    checks++;
    if (bus.q !== 32'd0 || bus.r !== 32'd0) begin
      errors++;
      $display("FAIL abort_qr got %h/%h exp 0/0", bus.q, bus.r);
    end
    repeat (40) step();
    checks++;
    if (bus.divdone !== 1'b0 || bus.q !== 32'd0 ||
        bus.r !== 32'd0) begin
      errors++;
      $display("FAIL abort_late got d=%b q=%h r=%h exp 0/0/0",
               bus.divdone, bus.q, bus.r);
    end
  endtask

  task automatic test_ignore();
    int lat, bc, qm;
    do_start(1'b0, 32'd1000, 32'd10);
    wait_done(5, 32'd0, lat, bc, qm);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL ign_lat got %0d exp 34", lat);
    end
    checks++;
    if (bus.q !== 32'd100 || bus.r !== 32'd0) begin
      errors++;
      $display("FAIL ign_qr got %0d/%0d exp 100/0", bus.q, bus.r);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, qm;
    do_start(1'b0, 32'd100, 32'd7);
    wait_done(0, 32'd100, lat, bc, qm);
    checks++;
    if (bus.q !== 32'd14 || bus.r !== 32'd2) begin
      errors++;
      $display("FAIL b2b_first got %0d/%0d exp 14/2", bus.q, bus.r);
    end
    do_start(1'b0, 32'd9, 32'd4);
    checks++;
    if (bus.divdone !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_clr got d=%b b=%b exp 0/1",
               bus.divdone, bus.busy);
    end
    checks++;
    if (bus.q !== 32'd14 || bus.r !== 32'd2) begin
      errors++;
      $display("FAIL b2b_keep got %0d/%0d exp 14/2", bus.q, bus.r);
    end
    wait_done(0, 32'd14, lat, bc, qm);
    checks++;
    if (qm !== 0) begin
      errors++;
      $display("FAIL b2b_early got moved=%0d exp 0", qm);
    end
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL b2b_lat got %0d exp 34", lat);
    end
    checks++;
    if (bus.q !== 32'd2 || bus.r !== 32'd1) begin
      errors++;
      $display("FAIL b2b_qr got %0d/%0d exp 2/1", bus.q, bus.r);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    divrst      = 1'b1;
    bus.start   = 1'b0;
    bus.signdiv = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_overflow();
    test_abort();
    test_ignore();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_div.md
MIPS_CPU_DIV -- requirements
Module: mips_cpu_div

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; all latencies below are given for WIDTH=32 and scale as WIDTH+2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 divrst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse; samples a, b and signdiv when accepted.
REQ-005 signdiv  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-006 a  input  WIDTH  dividend.
REQ-007 b  input  WIDTH  divisor.
REQ-008 q  output  WIDTH  quotient, registered.
REQ-009 r  output  WIDTH  remainder, registered.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 divdone  output  1  high while q/r hold a valid result.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; start in CALC or FIX SHALL be ignored with no effect on the operation.
REQ-014 On acceptance, the block SHALL latch signdiv, the sign bits of a and b, and the magnitudes |a| and |b|.
- Magnitude = two's-complement negation when signdiv=1 and the MSB is set; otherwise the raw value.
REQ-015 On acceptance with b!=0, the FSM SHALL enter CALC with iteration counter = 0, busy=1 and divdone=0.
REQ-016 CALC SHALL perform one restoring shift-subtract iteration per cycle, MSB first, for exactly WIDTH cycles.
- Each iteration: shift the partial remainder left by one, bringing in the next dividend bit.
- Subtract the divisor magnitude if the result is non-negative; shift the quotient bit in.
REQ-017 After the last CALC iteration, the FSM SHALL enter FIX for one cycle and apply signs:
- quotient negated iff signdiv=1 and the sign of a differs from the sign of b;
- remainder negated iff signdiv=1 and a was negative.
REQ-018 From FIX, the FSM SHALL enter DONE, loading q and r and setting divdone=1 and busy=0.
- divdone SHALL first be high 34 cycles after the accepting edge.
REQ-019 DONE SHALL hold q, r and divdone stable indefinitely until divrst or the next accepted start.
REQ-020 Back-to-back operation: start accepted in DONE SHALL clear divdone on the next edge and begin CALC with the new operands; q/r SHALL keep the old values until the new result loads.
REQ-021 Divide-by-zero (b==0 at acceptance) SHALL skip CALC/FIX and enter DONE on the next edge, for either signdiv value:
- q = all ones;
- r = a, unmodified.
REQ-022 Signed overflow (a=most-negative, b=-1, signdiv=1) SHALL yield q=a and r=0 through the normal path, with no special case.
REQ-023 Operand inputs SHALL be don't-care after acceptance; changes to them SHALL NOT affect an operation in progress.
REQ-024 All outputs SHALL be driven directly from registers, with no combinational path from the inputs.

Reset
REQ-025 divrst=1 SHALL, on the next edge and from any state, force the following:
- IDLE;
- q=0, r=0;
- busy=0, divdone=0;
- counter=0.
REQ-026 divrst SHALL take priority over a simultaneous start.
REQ-027 divrst asserted mid-CALC SHALL abort the operation, with no partial result visible afterwards.

Verification
REQ-028 Unsigned: a=100, b=7, signdiv=0, start 1 cycle -> busy high for 33 cycles; divdone=1 at cycle 34; q=14, r=2.
REQ-029 Signed: a=-7 (FFFFFFF9), b=2, signdiv=1 -> q=FFFFFFFD (-3), r=FFFFFFFF (-1).
- Same operands with signdiv=0 -> q=7FFFFFFC, r=1.
REQ-030 Divide-by-zero: a=5, b=0 -> divdone=1 on the edge after acceptance; q=FFFFFFFF, r=5; busy never high.
REQ-031 Overflow: a=80000000, b=FFFFFFFF, signdiv=1 -> q=80000000, r=0 at cycle 34.
REQ-032 Abort and ignore:
- divrst at cycle 10 of CALC -> next edge busy=0, divdone=0, q=r=0.
- A separate run with a start pulse during CALC -> the original result is unchanged and the latency is still 34.
REQ-033 Back-to-back: after 100/7 completes, start 9/4 in DONE -> divdone low next cycle; q stays 14 until the new result q=2, r=1 loads 34 cycles after the second start.
